// File: rtl/sort_stream_checker.sv
// Captures one sorted run from the Sorter, checks ordering and word count,
// accumulates min/max/checksum, and offers registered buffer readback.
module sort_stream_checker #(
   parameter int DATA_W  = 32,
   parameter int N       = 128,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [DATA_W-1:0]    din,
   input  logic [CNT_W-1:0]     in_cnt,
   input  logic                 started,
   input  logic                 finished,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 err_order,
   output logic                 err_count,
   output logic                 err_timeout,
   output logic [CNT_W-1:0]     err_index,
   output logic [CNT_W-1:0]     word_cnt,
   output logic [DATA_W-1:0]    min_val,
   output logic [DATA_W-1:0]    max_val,
   output logic [DATA_W-1:0]    checksum
);

   localparam int ADDR_W = $clog2(N);
   localparam int TMR_W  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

   logic [1:0]        state_q, state_d;
   logic              started_q;
   logic [CNT_W-1:0]  expect_q, expect_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [DATA_W-1:0] min_q, min_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              err_order_q, err_order_d;
   logic              err_count_q, err_count_d;
   logic              err_timeout_q, err_timeout_d;
   logic [CNT_W-1:0]  err_index_q, err_index_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] mem_q [N];

   logic              start_edge_s;
   logic              hold_s;
   logic              accept_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] wr_addr_s;

   assign start_edge_s = started & ~started_q & ena;
   assign hold_s       = (in_cnt == (expect_q - CNT_ONE));
   assign accept_s     = ena & (state_q == S_CAPTURE) & ~hold_s & ~start_edge_s;

   // Next-state and run statistics; a start edge wins over everything else.
   always_comb begin
      state_d       = state_q;
      expect_d      = expect_q;
      timer_d       = timer_q;
      word_cnt_d    = word_cnt_q;
      min_d         = min_q;
      max_d         = max_q;
      sum_d         = sum_q;
      err_order_d   = err_order_q;
      err_count_d   = err_count_q;
      err_timeout_d = err_timeout_q;
      err_index_d   = err_index_q;
      wr_en_s       = 1'b0;
      wr_addr_s     = {ADDR_W{1'b0}};
      if (start_edge_s) begin
         state_d       = S_CAPTURE;
         expect_d      = CNT_ONE;
         timer_d       = {TMR_W{1'b0}};
         word_cnt_d    = CNT_ONE;
         min_d         = din;
         max_d         = din;
         sum_d         = din;
         err_order_d   = 1'b0;
         err_count_d   = 1'b0;
         err_timeout_d = 1'b0;
         err_index_d   = {CNT_W{1'b0}};
         wr_en_s       = 1'b1;
      end else if (ena && (state_q == S_CAPTURE)) begin
         if (hold_s) begin
            timer_d = timer_q + TMR_ONE;
         end else begin
            // Out-of-sequence index: flag it, then resync on the word as presented.
            err_count_d = err_count_q | (in_cnt != expect_q);
            expect_d    = in_cnt + CNT_ONE;
            timer_d     = {TMR_W{1'b0}};
            word_cnt_d  = word_cnt_q + CNT_ONE;
            sum_d       = sum_q + din;
            max_d       = din;
            wr_en_s     = 1'b1;
            wr_addr_s   = in_cnt[ADDR_W-1:0];
            if (din < max_q) begin
               err_order_d = 1'b1;
               if (!err_order_q) begin
                  err_index_d = in_cnt;
               end else begin
                  err_index_d = err_index_q;
               end
            end else begin
               err_order_d = err_order_q;
            end
         end
         err_count_d   = err_count_d | (finished & (word_cnt_d != N_CNT));
         err_timeout_d = err_timeout_q | (timer_d == TMR_MAX);
         if ((accept_s && (in_cnt >= LAST_IDX)) || finished || (timer_d == TMR_MAX)) begin
            state_d = S_DONE;
         end else begin
            state_d = S_CAPTURE;
         end
      end else begin
         state_d = state_q;
      end
   end

   assign busy_d = (state_d == S_CAPTURE);
   assign done_d = (state_d == S_DONE);
   assign pass_d = done_d & ~(err_order_d | err_count_d | err_timeout_d) & (word_cnt_d == N_CNT);

   // Control and summary registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         started_q     <= 1'b0;
         expect_q      <= {CNT_W{1'b0}};
         timer_q       <= {TMR_W{1'b0}};
         word_cnt_q    <= {CNT_W{1'b0}};
         min_q         <= {DATA_W{1'b0}};
         max_q         <= {DATA_W{1'b0}};
         sum_q         <= {DATA_W{1'b0}};
         err_order_q   <= 1'b0;
         err_count_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         err_index_q   <= {CNT_W{1'b0}};
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         rd_data_q     <= {DATA_W{1'b0}};
      end else begin
         state_q       <= state_d;
         started_q     <= started;
         expect_q      <= expect_d;
         timer_q       <= timer_d;
         word_cnt_q    <= word_cnt_d;
         min_q         <= min_d;
         max_q         <= max_d;
         sum_q         <= sum_d;
         err_order_q   <= err_order_d;
         err_count_q   <= err_count_d;
         err_timeout_q <= err_timeout_d;
         err_index_q   <= err_index_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         rd_data_q     <= mem_q[rd_addr];
      end
   end

   // Capture buffer; deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en_s && !rst) begin
         mem_q[wr_addr_s] <= din;
      end
   end

   assign rd_data     = rd_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_order   = err_order_q;
   assign err_count   = err_count_q;
   assign err_timeout = err_timeout_q;
   assign err_index   = err_index_q;
   assign word_cnt    = word_cnt_q;
   assign min_val     = min_q;
   assign max_val     = max_q;
   assign checksum    = sum_q;

endmodule

// File: doc/sort_stream_checker.md
Name: sort_stream_checker

Overview:
Downstream consumer of the Sorter output stream. Captures the N sorted words as the Sorter emits them (dout indexed by out_cnt, framed by started/finished) into a local buffer. Checks non-decreasing order and word count, and accumulates min/max/checksum. Exposes a pass/fail summary plus a random-access readback port for board-level self-test without a testbench file dump.

Parameters:
DATA_W, 32, width of each sorted word
N, 128, words per sort run
CNT_W, 8, width of the Sorter index/counter bus
TIMEOUT, 1024, max cycles between accepted words before a timeout error

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ena  in  1  global enable; when low the FSM holds its state and accepts nothing
din  in  DATA_W  Sorter dout
in_cnt  in  CNT_W  Sorter out_cnt, index of the word on din
started  in  1  Sorter started; its rising edge marks word 0 valid
finished  in  1  Sorter finished
rd_addr  in  log2(N)  readback address
rd_data  out  DATA_W  buffer[rd_addr], registered
busy  out  1  capture in progress
done  out  1  run complete, summary valid
pass  out  1  done and no error flags set
err_order  out  1  sticky: some word was smaller than its predecessor
err_count  out  1  sticky: index skip, or finished seen with word_cnt != N
err_timeout  out  1  sticky: TIMEOUT cycles elapsed without a new word
err_index  out  CNT_W  index of the first order violation, 0 if none
word_cnt  out  CNT_W  words accepted this run
min_val  out  DATA_W  first accepted word
max_val  out  DATA_W  last accepted word
checksum  out  DATA_W  sum of accepted words, mod 2^DATA_W

Behaviour:
- Reset values: all outputs 0, FSM = IDLE. Buffer contents are not reset and stay undefined until written.
- started_d is a registered copy of started. A start edge is started & ~started_d & ena.
- IDLE:
  - on a start edge, accept din as index 0: buf[0]=din, min_val=max_val=checksum=din, word_cnt=1, expect=1.
  - clear all err flags and done; go CAPTURE; busy=1.
- CAPTURE, per enabled cycle:
  - in_cnt == expect: accept. buf[expect]=din, checksum+=din, word_cnt+=1, expect+=1, idle_timer=0.
    - Unsigned compare against max_val: if din < max_val, set err_order and, if first violation, err_index=expect.
    - max_val=din.
  - in_cnt == expect-1 (holding): no accept; idle_timer+=1.
  - Any other in_cnt: err_count=1; resync expect=in_cnt+1 and accept din as above.
  - Accepting index N-1 -> DONE on the next cycle.
  - finished=1 before N words accepted -> err_count=1, go DONE.
  - idle_timer reaches TIMEOUT -> err_timeout=1, go DONE.
  - Priority within one cycle: accept first, then finished/timeout evaluation.
- DONE:
  - busy=0, done=1, pass = ~(err_order|err_count|err_timeout) & (word_cnt==N).
  - Hold until rst or a new start edge. A start edge re-enters CAPTURE with word 0 accepted that same cycle, as in IDLE.
- A start edge during CAPTURE restarts the run: counters and flags clear, word 0 is accepted.
- ena low: no accept, timer frozen, state held; started_d still updates.
- rd_data = buf[rd_addr], registered with 1-cycle latency, valid in any state. A read of the address being written the same cycle returns the old contents.
- rst mid-capture: returns to IDLE with all outputs 0 on the next edge.
- Equal adjacent words are legal and do not set err_order.
- checksum wraps modulo 2^DATA_W with no overflow flag.

Test Plan:
1. Feed values 0..127 ascending, one per cycle after a started edge, then finished -> word_cnt=128, pass=1, min=0, max=127, checksum=8128; rd_addr=5 gives rd_data=5 one cycle later.
2. Same stream with word 40 = 1000 and word 41 = 41 -> err_order=1, err_index=41, pass=0; continuing with no further violations leaves err_index at 41.
3. in_cnt jumps 10->12 -> err_count=1, word_cnt=127; finished at index 127 -> done=1, pass=0.
4. Stream stalls at index 20 for TIMEOUT cycles -> err_timeout=1, done=1, busy=0, word_cnt=21.
5. rst asserted at index 64 -> next cycle all outputs 0, state IDLE. A fresh full ascending run of all 0xFFFFFFFF words -> pass=1, checksum=0xFFFFFF80.
6. From DONE, pulse started with ena low -> no restart; then raise ena and pulse started -> flags clear, word_cnt=1, busy=1.
